key_sel_ctrl: RTL and testbench
===============================

# key_sel_ctrl

Debounced key-driven select generator that produces the `sel` control for the downstream 2:1 selector stage. A raw, bouncing, active-low push-button input is synchronized, filtered by a press/release state machine and converted into a single toggle of `sel` per clean press. A one-cycle `key_flag` pulse marks each accepted press for other consumers.

## Interface
- `CNT_MAX`, default 20'd999_999: filter length in clock cycles minus one (20 ms at 50 MHz); width of filter counter = 20 bits.
- `AUTO_MAX`, default 26'd49_999_999: auto-toggle period minus one (1 s at 50 MHz); used only with `KEY_SEL_AUTO_EN`.
- `sys_clk` input 1: single system clock, all logic on rising edge.
- `sys_rst_n` input 1: asynchronous, active-low reset.
- `key_in` input 1: raw push-button, active low (pressed = 0), asynchronous to `sys_clk`.
- `sel` output 1: registered select to downstream selector; 0 = first input, 1 = second input.
- `key_flag` output 1: registered one-cycle pulse on each accepted press.

## Operation
- Synchronizer: two flops `key_s1`, `key_s2`, reset to 1; `key_s2` is the only key value used by the FSM.
- FSM states: IDLE, PRESS_FILTER, PRESSED, RELEASE_FILTER; reset state IDLE; filter counter `cnt` resets to 0.
- IDLE: `key_s2`=0 -> PRESS_FILTER, `cnt`<=0; else stay.
- PRESS_FILTER: `key_s2`=1 -> IDLE, `cnt`<=0 (bounce rejected). `key_s2`=0 and `cnt`<CNT_MAX -> `cnt`+1. `key_s2`=0 and `cnt`==CNT_MAX -> PRESSED, `cnt`<=0, `key_flag`<=1, `sel`<=~`sel`.
- PRESSED: `key_s2`=1 -> RELEASE_FILTER, `cnt`<=0; else stay (holding key never retriggers).
- RELEASE_FILTER: `key_s2`=0 -> PRESSED, `cnt`<=0; `key_s2`=1 and `cnt`==CNT_MAX -> IDLE, `cnt`<=0; else `cnt`+1.
- `key_flag` is 0 in every cycle other than the PRESS_FILTER->PRESSED transition.
- Counter never wraps: saturates at the transition compare; width fixed 20 bits, CNT_MAX must fit.

## Timing
- Reset values: `sel`=0, `key_flag`=0, state IDLE, `cnt`=0, `key_s1`=`key_s2`=1.
- `key_in` sampled 0 at edge 1 and held low: `key_s2`=0 after edge 2, PRESS_FILTER after edge 3, `key_flag`=1 and `sel` toggled after edge CNT_MAX+4; `key_flag` back to 0 after edge CNT_MAX+5.
- Any high sample reaching `key_s2` during PRESS_FILTER restarts the full filter.
- Minimum press-to-press spacing: release must be stable CNT_MAX+1 cycles before a new press is accepted.
- Reset asserted mid-filter or while PRESSED: all state returns to reset values immediately; key still held low after reset release must complete a full press filter and toggles `sel` to 1.

## Configuration
- `KEY_SEL_AUTO_EN` defined: adds 26-bit free counter `auto_cnt` (reset 0); when `auto_cnt`==AUTO_MAX, `sel` toggles and `auto_cnt`<=0; an accepted key press also clears `auto_cnt`. Key press and auto tick in the same cycle -> exactly one toggle, `auto_cnt`<=0. `key_flag` never pulses on auto toggles.
- Not defined: no `auto_cnt`, `AUTO_MAX` unused; `sel` changes only on accepted presses.

## Structure
- Shared package `key_sel_pkg`: FSM state encoding (2-bit localparams IDLE=0, PRESS_FILTER=1, PRESSED=2, RELEASE_FILTER=3) and default CNT_MAX/AUTO_MAX constants.
- One sub-module `key_sync2`: two-flop synchronizer, reset value 1; FSM, counter and `sel` register remain in `key_sel_ctrl`.

## Test plan (CNT_MAX=4, AUTO_MAX=15 for simulation)
- Reset release, `key_in`=1 for 50 cycles -> `sel`=0, `key_flag`=0 throughout.
- Clean press held 20 cycles -> `key_flag` high exactly one cycle at edge 8 after first low sample, `sel` 0->1; no further pulse while held.
- Bounce: low 3 cycles, high 1, low 3, high -> no `key_flag`, `sel` stays 0.
- Two clean presses separated by 10-cycle release -> two pulses, `sel` 0->1->0; release glitch of 2 cycles between them -> only one pulse.
- Reset asserted in PRESS_FILTER with key low, released with key low -> outputs 0 during reset, one pulse CNT_MAX+4 edges after release, `sel`=1.
- With `KEY_SEL_AUTO_EN`, no key -> `sel` toggles every 16 cycles, `key_flag` stays 0; press coinciding with auto tick -> single toggle.

Source files
------------

// File: rtl/key_sel_pkg.sv
// Shared definitions for the key-driven select generator: FSM encoding and
// default filter / auto-toggle lengths (50 MHz system clock).
package key_sel_pkg;

  typedef enum logic [1:0] {
    IDLE           = 2'd0,
    PRESS_FILTER   = 2'd1,
    PRESSED        = 2'd2,
    RELEASE_FILTER = 2'd3
  } key_state_t;

  localparam logic [19:0] CNT_MAX_DEF  = 20'd999_999;
  localparam logic [25:0] AUTO_MAX_DEF = 26'd49_999_999;

endpackage

// File: rtl/key_sync2.sv
// Two-flop synchronizer for the raw push-button; idles high (key released).
module key_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic key_s1;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // their inputs on the same edge and form a real two-stage chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1 <= 1'b1;
      q      <= 1'b1;
    end else begin
      key_s1 <= d;
      q      <= key_s1;
    end
  end

endmodule

// File: rtl/key_sel_ctrl.sv
// Debounced press/release FSM that toggles sel once per clean key press and
// pulses key_flag. Define KEY_SEL_AUTO_EN to add a periodic auto-toggle of sel.
module key_sel_ctrl
  import key_sel_pkg::*;
#(
  parameter logic [19:0] CNT_MAX  = CNT_MAX_DEF,
  parameter logic [25:0] AUTO_MAX = AUTO_MAX_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic sel,
  output logic key_flag
);

  key_state_t  state;
  logic [19:0] cnt;
  logic        key_s2;
  logic        press_ok;
  logic        toggle;

  // A zero auto period would flip sel on every clock.
  if (AUTO_MAX == '0) begin : g_auto_max_invalid
    $error("key_sel_ctrl: AUTO_MAX must be non-zero");
  end

  key_sync2 u_sync (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .d     (key_in),
    .q     (key_s2)
  );

  assign press_ok = (state == PRESS_FILTER) && !key_s2 && (cnt == CNT_MAX);

`ifdef KEY_SEL_AUTO_EN
  logic [25:0] auto_cnt;
  logic        auto_tick;

  assign auto_tick = (auto_cnt == AUTO_MAX);
  // A press and an auto tick landing together still give a single toggle.
  assign toggle    = press_ok || auto_tick;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      auto_cnt <= '0;
    else if (toggle)
      auto_cnt <= '0;
    else
      auto_cnt <= auto_cnt + 26'd1;
  end
`else
  assign toggle = press_ok;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      key_flag <= 1'b0;
      sel      <= 1'b0;
    end else begin
      key_flag <= press_ok;
      if (toggle)
        sel <= ~sel;

      case (state)
        IDLE: begin
          if (!key_s2) begin
            state <= PRESS_FILTER;
            cnt   <= '0;
          end
        end
        PRESS_FILTER: begin
          if (key_s2) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state <= PRESSED;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 20'd1;
          end
        end
        PRESSED: begin
          if (key_s2) begin
            state <= RELEASE_FILTER;
            cnt   <= '0;
          end
        end
        RELEASE_FILTER: begin
          if (!key_s2) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 20'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_sel_ctrl.sv
// Directed self-checking bench for key_sel_ctrl with a short filter (CNT_MAX=4)
// and short auto period (AUTO_MAX=15); the auto sequence runs with KEY_SEL_AUTO_EN.
module tb_key_sel_ctrl;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  logic key_in    = 1'b1;
  logic sel;
  logic key_flag;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_n;
  int pulses;
  int last_pulse_edge;
  int sel_hi_cycles;

  always #5 sys_clk = ~sys_clk;

  key_sel_ctrl #(
    .CNT_MAX  (20'd4),
    .AUTO_MAX (26'd15)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_in    (key_in),
    .sel       (sel),
    .key_flag  (key_flag)
  );

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    else
      n_pass++;
  endtask

  task automatic clear_stats();
    edge_n          = 0;
    pulses          = 0;
    last_pulse_edge = -1;
    sel_hi_cycles   = 0;
  endtask

  // One clock: sample outputs 1 ns after the rising edge.
  task automatic tick();
    @(posedge sys_clk);
    #1;
    edge_n++;
    if (key_flag === 1'b1) begin
      pulses++;
      last_pulse_edge = edge_n;
    end
    if (sel === 1'b1)
      sel_hi_cycles++;
  endtask

  task automatic run(input logic k, input int n);
    key_in = k;
    repeat (n) tick();
  endtask

  initial begin
    clear_stats();
    #1;
    check("reset_sel", int'(sel), 0);
    check("reset_flag", int'(key_flag), 0);
    repeat (3) tick();
    sys_rst_n = 1'b1;

`ifdef KEY_SEL_AUTO_EN
    // No key: sel flips on every 16th edge, never flags.
    clear_stats();
    run(1'b1, 15);
    check("auto_before_tick_sel", int'(sel), 0);
    run(1'b1, 1);
    check("auto_tick1_sel", int'(sel), 1);
    run(1'b1, 16);
    check("auto_tick2_sel", int'(sel), 0);
    check("auto_no_flag", pulses, 0);
    // Press accepted exactly on the third auto tick (edge 48).
    run(1'b1, 8);
    run(1'b0, 8);
    check("coincide_pulse_edge", last_pulse_edge, 48);
    check("coincide_single_toggle", int'(sel), 1);
    run(1'b0, 15);
    check("auto_cleared_sel_hold", int'(sel), 1);
    run(1'b0, 1);
    check("auto_after_clear_sel", int'(sel), 0);
    check("auto_total_pulses", pulses, 1);
`else
    // Idle key.
    clear_stats();
    run(1'b1, 50);
    check("idle_pulses", pulses, 0);
    check("idle_sel_hi", sel_hi_cycles, 0);
    check("idle_sel", int'(sel), 0);

    // Bounce: never stays low long enough to pass the filter.
    clear_stats();
    run(1'b0, 3);
    run(1'b1, 1);
    run(1'b0, 3);
    run(1'b1, 10);
    check("bounce_pulses", pulses, 0);
    check("bounce_sel_hi", sel_hi_cycles, 0);

    // Clean press held 20 cycles.
    clear_stats();
    run(1'b0, 20);
    check("press1_pulses", pulses, 1);
    check("press1_edge", last_pulse_edge, 8);
    check("press1_sel", int'(sel), 1);
    check("press1_sel_hi", sel_hi_cycles, 13);
    run(1'b1, 10);

    // Second clean press after a 10-cycle release.
    clear_stats();
    run(1'b0, 20);
    check("press2_pulses", pulses, 1);
    check("press2_edge", last_pulse_edge, 8);
    check("press2_sel", int'(sel), 0);
    run(1'b1, 10);

    // Two-cycle release glitch must not produce a second press.
    clear_stats();
    run(1'b0, 10);
    run(1'b1, 2);
    run(1'b0, 10);
    run(1'b1, 10);
    check("glitch_pulses", pulses, 1);
    check("glitch_sel", int'(sel), 1);

    // Reset in the middle of the press filter with the key still held.
    clear_stats();
    run(1'b0, 5);
    sys_rst_n = 1'b0;
    #1;
    check("midrst_sel", int'(sel), 0);
    check("midrst_flag", int'(key_flag), 0);
    clear_stats();
    repeat (3) tick();
    check("midrst_hold_pulses", pulses, 0);
    check("midrst_hold_sel_hi", sel_hi_cycles, 0);
    sys_rst_n = 1'b1;
    clear_stats();
    run(1'b0, 15);
    check("postrst_pulses", pulses, 1);
    check("postrst_edge", last_pulse_edge, 8);
    check("postrst_sel", int'(sel), 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
